// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: elastic valid/ready pipeline stage with a two-entry skid buffer,
// flush and bubble-safe control gating; STAGE_STATS_EN adds stall/bubble counters.
module pipe_stage_elastic #(
  parameter int DATA_W = 101,
  parameter int CTRL_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);
  typedef enum logic [1:0] {EMPTY, HALF, FULL} state_t;
  state_t r_state, w_next;
  logic [CTRL_W-1:0] r_main_ctrl, r_skid_ctrl;
  logic [DATA_W-1:0] r_main_data, r_skid_data;
  logic w_in_fire, w_out_fire, w_load_main, w_load_skid;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;
  always_ff @(posedge clk)
    if (rst) r_state <= EMPTY;
    else     r_state <= w_next;
  always_comb
    w_next = flush             ? EMPTY :
             r_state == EMPTY  ? (w_in_fire ? HALF : EMPTY) :
             r_state == HALF   ? (w_in_fire & ~w_out_fire ? FULL :
                                  ~w_in_fire & w_out_fire ? EMPTY : HALF) :
                                 (w_out_fire ? HALF : FULL);
  always_comb begin
    out_valid = r_state != EMPTY;
    in_ready  = (r_state != FULL) & ~rst;
    out_ctrl  = out_valid ? r_main_ctrl : '0;
    out_data  = r_main_data;
  end
  // main refills from the skid when draining FULL, otherwise straight from the input
  assign w_load_main = ~flush & ((r_state == EMPTY & w_in_fire) |
                                 (r_state == HALF & w_in_fire & w_out_fire) |
                                 (r_state == FULL & w_out_fire));
  assign w_load_skid = ~flush & r_state == HALF & w_in_fire & ~w_out_fire;
  always_ff @(posedge clk)
    if (rst) begin
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else begin
      if (w_load_main) begin
        r_main_ctrl <= r_state == FULL ? r_skid_ctrl : in_ctrl;
        r_main_data <= r_state == FULL ? r_skid_data : in_data;
      end
      if (w_load_skid) begin
        r_skid_ctrl <= in_ctrl;
        r_skid_data <= in_data;
      end
    end
`ifdef STAGE_STATS_EN
  logic [CNT_W-1:0] r_stall_cnt, r_bubble_cnt;
  always_ff @(posedge clk)
    if (rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (out_valid & ~out_ready & ~&r_stall_cnt) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (~out_valid & ~&r_bubble_cnt) r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic: randomized and directed checks of pipe_stage_elastic against a queue model.
module tb_pipe_stage_elastic;
  localparam int DW = 101, CW = 3, NW = 4, CMAX = 15;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic in_ready, out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [NW-1:0] stall_cnt, bubble_cnt;
  int vectors = 0, miscompares = 0, es = 0, eb = 0;
  typedef struct {logic [CW-1:0] c; logic [DW-1:0] d;} ent_t;
  ent_t q[$];

  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt));

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, 5'($urandom)};
  endfunction

  // one clock: drive, check mid-cycle against the queue model, then advance the model
  task automatic step(input logic iv, input logic [CW-1:0] ic, input logic [DW-1:0] id,
                      input logic ordy, input logic fl);
    logic exp_rdy, inf, outf;
    logic [CW-1:0] exp_c;
    in_valid = iv; in_ctrl = ic; in_data = id; out_ready = ordy; flush = fl;
    @(negedge clk);
    exp_rdy = (q.size() < 2) && !rst;
    exp_c = q.size() != 0 ? q[0].c : '0;
    vectors++;
    if (in_ready !== exp_rdy) begin
      miscompares++; $display("FAIL in_ready got %b expected %b", in_ready, exp_rdy);
    end
    if (out_valid !== (q.size() != 0)) begin
      miscompares++; $display("FAIL out_valid got %b expected %b", out_valid, q.size() != 0);
    end
    if (out_ctrl !== exp_c) begin
      miscompares++; $display("FAIL out_ctrl got %h expected %h", out_ctrl, exp_c);
    end
    if (q.size() != 0 && out_data !== q[0].d) begin
      miscompares++; $display("FAIL out_data got %h expected %h", out_data, q[0].d);
    end
`ifdef STAGE_STATS_EN
    if (stall_cnt !== NW'(es) || bubble_cnt !== NW'(eb)) begin
      miscompares++; $display("FAIL counters got %0d/%0d expected %0d/%0d", stall_cnt, bubble_cnt, es, eb);
    end
`else
    if (stall_cnt !== '0 || bubble_cnt !== '0) begin
      miscompares++; $display("FAIL counters_tied got %0d/%0d expected 0/0", stall_cnt, bubble_cnt);
    end
`endif
    inf = iv && exp_rdy;
    outf = q.size() != 0 && ordy;
    @(posedge clk); #1;
    if (rst) begin
      q.delete(); es = 0; eb = 0;
    end else begin
      if (q.size() != 0 && !ordy && es < CMAX) es++;
      if (q.size() == 0 && eb < CMAX) eb++;
      if (fl) q.delete();
      else begin
        if (outf) void'(q.pop_front());
        if (inf) q.push_back('{ic, id});
      end
    end
  endtask

  task automatic test_reset();
    rst = 1;
    for (int i = 0; i < 3; i++) step(1, 3'b111, rnd_data(), 1, 0);
    vectors++;
    if (out_data !== '0) begin
      miscompares++; $display("FAIL reset_data got %h expected 0", out_data);
    end
    rst = 0;
    step(0, '0, '0, 1, 0);
  endtask

  task automatic test_stream();
    for (int i = 0; i < 8; i++) step(1, 3'b101, DW'(i), 1, 0);
    step(0, '0, '0, 1, 0);
    step(0, '0, '0, 1, 0);
  endtask

  task automatic test_backpressure();
    step(1, 3'd1, DW'('hA), 0, 0);
    step(1, 3'd2, DW'('hB), 0, 0);
    step(1, 3'd3, DW'('hC), 0, 0);
    step(1, 3'd3, DW'('hC), 0, 0);
    step(1, 3'd3, DW'('hC), 1, 0);
    step(1, 3'd3, DW'('hC), 1, 0);
    for (int i = 0; i < 3; i++) step(0, '0, '0, 1, 0);
  endtask

  task automatic test_simultaneous();
    step(1, 3'd6, DW'('h111), 0, 0);
    step(1, 3'd2, DW'('h222), 1, 0);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== DW'('h222) || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL simultaneous got v=%b d=%h r=%b expected v=1 d=222 r=1", out_valid, out_data, in_ready);
    end
    step(0, '0, '0, 1, 0);
  endtask

  task automatic test_flush();
    step(1, 3'd1, DW'('h10), 0, 0);
    step(1, 3'd2, DW'('h20), 0, 0);
    step(1, 3'd7, DW'('hDEAD), 0, 1);
    vectors++;
    if (out_valid !== 1'b0 || out_ctrl !== '0) begin
      miscompares++; $display("FAIL flush got v=%b c=%h expected v=0 c=0", out_valid, out_ctrl);
    end
    step(1, 3'd4, DW'('h40), 1, 0);
    step(0, '0, '0, 1, 0);
    step(0, '0, '0, 1, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(63) == 0);
      step($urandom_range(3) != 0, 3'($urandom), rnd_data(), $urandom_range(2) != 0,
           $urandom_range(19) == 0);
    end
    rst = 0;
    step(0, '0, '0, 1, 0);
  endtask

`ifdef STAGE_STATS_EN
  task automatic test_stats();
    rst = 1; step(0, '0, '0, 1, 0); rst = 0;
    step(1, 3'd5, DW'('h55), 0, 0);
    for (int i = 0; i < 20; i++) step(0, '0, '0, 0, 0);
    vectors++;
    if (stall_cnt !== 4'd15) begin
      miscompares++; $display("FAIL stall_sat got %0d expected 15", stall_cnt);
    end
    step(0, '0, '0, 0, 1);
    vectors++;
    if (stall_cnt !== 4'd15) begin
      miscompares++; $display("FAIL stall_flush got %0d expected 15", stall_cnt);
    end
    rst = 1; step(0, '0, '0, 1, 0);
    vectors++;
    if (stall_cnt !== '0 || bubble_cnt !== '0) begin
      miscompares++; $display("FAIL stats_rst got %0d/%0d expected 0/0", stall_cnt, bubble_cnt);
    end
    rst = 0;
  endtask
`endif

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_simultaneous();
    test_flush();
    test_random();
`ifdef STAGE_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
Parametrised, elastic successor to the fixed MEM/WB stage register. Carries an arbitrary control bundle and data bundle between two pipeline stages using a valid/ready handshake. A two-entry skid buffer provides full throughput under backpressure with no combinational ready path. Adds flush (bubble insertion) and bubble-safe control gating, so a stalled or flushed stage never presents live control such as RegWrite.

Parameters:
DATA_W, 101, width of data bundle (default = ALUResult 32 + ReadData 32 + PCPlus4 32 + Rd 5)
CTRL_W, 3, width of control bundle (default = RegWrite 1 + ResultSrc 2)
CNT_W, 16, width of statistics counters (used only with the optional feature)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous reset, active-high
flush  in  1  synchronous flush; discards all held entries
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept an entry this cycle
in_ctrl  in  CTRL_W  upstream control bundle
in_data  in  DATA_W  upstream data bundle
out_valid  out  1  downstream entry valid
out_ready  in  1  downstream accepts the entry this cycle
out_ctrl  out  CTRL_W  control bundle, forced to 0 when out_valid=0
out_data  out  DATA_W  data bundle; value undefined when out_valid=0
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0 (STAGE_STATS_EN only)
bubble_cnt  out  CNT_W  cycles with out_valid=0 (STAGE_STATS_EN only)

Behaviour:
- Handshake signals: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Registers:
  - main slot (ctrl, data) drives the outputs.
  - skid slot (ctrl, data) holds one extra entry.
  - state is one of EMPTY, HALF, FULL.
- Derived outputs:
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL) & ~rst. It depends on registered state only and has no combinational path from out_ready.
  - out_ctrl = main_ctrl when out_valid=1, else 0.
- State transitions (when rst=0 and flush=0):
  - EMPTY: in_fire -> main<=in, go to HALF.
  - HALF, in_fire & out_fire: main<=in, stay in HALF.
  - HALF, in_fire only: skid<=in, go to FULL.
  - HALF, out_fire only: go to EMPTY.
  - HALF, neither: hold.
  - FULL, out_fire: main<=skid, go to HALF. in_fire is impossible because in_ready=0.
  - FULL, otherwise: hold.
- Latency: 1 cycle from in_fire to out_valid when EMPTY. Throughput: 1 entry/cycle sustained while out_ready=1.
- Ordering: strict FIFO. The skid entry never overtakes the main entry.
- Stall hold: while out_valid=1 and out_ready=0, out_ctrl and out_data stay stable.
- Flush: state<=EMPTY on the next edge.
  - Any in_fire in the flush cycle is discarded.
  - Data registers may hold stale values, but out_ctrl reads 0 from the next cycle.
  - flush has priority over in_fire and out_fire. The downstream may still sample the current output during the flush cycle.
- Reset (rst=1): takes priority over flush.
  - state<=EMPTY, main and skid ctrl<=0, data<=0.
  - Outputs during and after reset: out_valid=0, out_ctrl=0, out_data=0.
  - in_ready=0 while rst=1, then 1 on the first cycle after rst deasserts.
  - A reset asserted mid-stream drops all held entries.
- No arithmetic on the bundles; widths pass through unchanged.

Optional Feature:
Macro STAGE_STATS_EN.
- Defined:
  - stall_cnt increments each cycle with out_valid=1 & out_ready=0.
  - bubble_cnt increments each cycle with out_valid=0 & rst=0.
  - Both saturate at all-ones (no wrap), reset to 0 on rst, and are unaffected by flush.
- Undefined: the counter logic is removed and stall_cnt and bubble_cnt are tied to 0. Port list is unchanged.

Test Plan:
- Reset: hold rst=1 for 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_ctrl=0, out_data=0. One cycle after release, in_ready=1.
- Streaming: out_ready=1, send 8 entries with ctrl=3'b101 and data=i -> each appears one cycle after its in_fire, in order. No cycle has in_ready=0.
- Backpressure: out_ready=0, offer A, B, C on consecutive cycles -> A and B accepted, state reaches FULL, in_ready=0 for C. Outputs hold A. Raise out_ready -> outputs A then B then C with no loss or duplication.
- Simultaneous: in HALF with in_fire and out_fire in the same cycle -> new entry replaces main, state stays HALF, skid untouched.
- Flush while FULL: flush=1 with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, and the offered entry is never output. The next accepted entry emerges with normal 1-cycle latency.
- Stats (STAGE_STATS_EN, CNT_W=4): 20 stall cycles -> stall_cnt=15, saturated. A subsequent flush leaves it at 15. rst clears both counters to 0.
